// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Purpose  : Shared line-level constants and receive FSM state encoding for
//             the serial framing path (common with the transmit-side control).
//  Revision : 1.0  initial release
// ============================================================================
package serial_pkg;

  // Receive FSM states; encoding is fixed so debug probes read the same on both sides
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Line levels: the line rests low, a frame opens with a high start bit
  // and closes with a low stop bit
  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rx_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rx_word_fifo
//  Purpose  : Small word buffer between the frame receiver and its consumer.
//             A push is accepted when full as long as a pop frees a slot in
//             the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module rx_word_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_CW-1:0]  r_count;

  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == c_CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage, pointers and occupancy; pointers wrap explicitly at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_rx
//  Purpose  : Rebuilds framed parallel words from the shift-register serial
//             stream, one bit per bit_en strobe. Checks start, even parity
//             and stop, and buffers good words behind a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             ser_in,
  input  logic             msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int             c_CW   = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  rx_state_t        r_state;
  rx_state_t        w_next;

  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_asm;
  logic             r_acc;
  logic             r_perr;
  logic             r_msb;

  logic             r_frame_err;
  logic             r_parity_err;
  logic             r_overrun;

  logic             w_start;
  logic             w_shift;
  logic             w_pchk;
  logic             w_push;
  logic             w_ferr;
  logic             w_perr;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign out_valid  = !w_empty;
  assign w_pop      = out_valid && out_ready;
  assign busy       = (r_state != IDLE);
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-strobe actions; nothing moves without a strobe
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_pchk  = 1'b0;
    w_push  = 1'b0;
    w_ferr  = 1'b0;
    w_perr  = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (ser_in == START_BIT) begin
            w_next  = DATA;
            w_start = 1'b1;
          end
        end
        DATA: begin
          w_shift = 1'b1;
          if (r_cnt == c_LAST) begin
            w_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          w_pchk = 1'b1;
          w_next = STOP;
        end
        STOP: begin
          w_next = IDLE;
          // A bad stop bit outranks a parity error
          if (ser_in != STOP_BIT) begin
            w_ferr = 1'b1;
          end else if (r_perr) begin
            w_perr = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Bit counter, assembly shifter, parity accumulator and latched bit order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_asm  <= '0;
      r_acc  <= 1'b0;
      r_perr <= 1'b0;
      r_msb  <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt  <= '0;
        r_acc  <= 1'b0;
        r_perr <= 1'b0;
        r_msb  <= msb_first;
      end
      if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_acc ^ ser_in;
        if (r_msb) begin
          r_asm <= {r_asm[WIDTH-2:0], ser_in};
        end else begin
          r_asm <= {ser_in, r_asm[WIDTH-1:1]};
        end
      end
      if (w_pchk) begin
        // Even parity: data bits xor parity bit must be zero
        r_perr <= r_acc ^ ser_in;
      end
    end
  end

  // One-cycle status pulses, registered off the stop strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
      r_overrun    <= w_push && w_full && !w_pop;
    end
  end

  rx_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_asm),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_frame_rx
//  Purpose  : Directed self-checking bench for serial_frame_rx
//             (WIDTH=4, even parity, 2-entry buffer).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       ser_in;
  logic       msb_first;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int         n_checks;
  int         n_pass;
  logic       pre_valid;

  serial_frame_rx #(
    .WIDTH      (4),
    .PARITY_EN  (1),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .ser_in     (ser_in),
    .msb_first  (msb_first),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Entered on a falling edge; optional idle gap, then a one-cycle strobe
  task automatic strobe(input logic b, input int maxgap, input logic rdy);
    repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    bit_en = 1'b1;
    ser_in = b;
    if (rdy) out_ready = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    ser_in = 1'b0;
    if (rdy) out_ready = 1'b0;
  endtask

  // Sends a full frame whose received word should be w under bit order msb
  task automatic send_frame(input logic [3:0] w, input logic msb, input logic pflip,
                            input logic stopv, input logic tog, input logic rdy_stop,
                            input int maxgap);
    logic b;
    msb_first = msb;
    strobe(1'b1, maxgap, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b = msb ? w[3-i] : w[i];
      strobe(b, maxgap, 1'b0);
      if (tog && i == 0) msb_first = ~msb_first;
    end
    strobe((^w) ^ pflip, maxgap, 1'b0);
    pre_valid = out_valid;
    strobe(stopv, 0, rdy_stop);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bit_en    = 1'b0;
    ser_in    = 1'b0;
    msb_first = 1'b0;
    out_ready = 1'b0;
    pre_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", out_data, 4'h0);
    check("rst_pulses", {frame_err, parity_err, overrun}, 3'b000);

    // Idle line with strobes does not start a frame
    strobe(1'b0, 0, 1'b0);
    check("idle_busy", busy, 1'b0);

    // LSB-first 1,0,1,0 -> 4'h5
    send_frame(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("t1_prevalid", pre_valid, 1'b0);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 4'h5);
    check("t1_pulses", {frame_err, parity_err, overrun}, 3'b000);
    check("t1_busy", busy, 1'b0);
    pop_one();
    check("t1_empty", out_valid, 1'b0);

    // Same line bits MSB-first -> 4'hA, msb_first toggled mid-frame
    send_frame(4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("t2_valid", out_valid, 1'b1);
    check("t2_data", out_data, 4'hA);
    pop_one();

    // Stop bit high -> frame error only
    send_frame(4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("t3_ferr", frame_err, 1'b1);
    check("t3_ferr_perr", parity_err, 1'b0);
    check("t3_ferr_valid", out_valid, 1'b0);
    @(negedge clk);
    check("t3_ferr_pulse", frame_err, 1'b0);

    // Parity flipped -> parity error only
    send_frame(4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("t3_perr", parity_err, 1'b1);
    check("t3_perr_ferr", frame_err, 1'b0);
    check("t3_perr_valid", out_valid, 1'b0);
    @(negedge clk);
    check("t3_perr_pulse", parity_err, 1'b0);

    // Both bad -> frame error wins
    send_frame(4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("t3_both", {frame_err, parity_err}, 2'b10);
    @(negedge clk);

    // Overflow with consumer stalled
    send_frame(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("t4_ovr_none", overrun, 1'b0);
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("t4_ovr", overrun, 1'b1);
    check("t4_head", out_data, 4'h1);
    @(negedge clk);
    check("t4_ovr_pulse", overrun, 1'b0);
    check("t4_hold", out_data, 4'h1);
    out_ready = 1'b1;
    check("t4_pop0", out_data, 4'h1);
    @(negedge clk);
    check("t4_pop1", out_data, 4'h2);
    check("t4_pop1_v", out_valid, 1'b1);
    @(negedge clk);
    check("t4_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Push coinciding with pop while full
    send_frame(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check("t5_no_ovr", overrun, 1'b0);
    check("t5_head2", out_data, 4'h2);
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_head3", out_data, 4'h3);
    check("t5_v3", out_valid, 1'b1);
    @(negedge clk);
    check("t5_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset mid-frame with strobe gaps, buffer holding a word
    send_frame(4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    check("t6_pre_data", out_data, 4'h7);
    strobe(1'b1, 3, 1'b0);
    strobe(1'b1, 3, 1'b0);
    strobe(1'b0, 3, 1'b0);
    check("t6_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_data", out_data, 4'h0);
    check("t6_rst_pulses", {frame_err, parity_err, overrun}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    check("t6_valid", out_valid, 1'b1);
    check("t6_data", out_data, 4'hC);
    check("t6_pulses", {frame_err, parity_err, overrun}, 3'b000);
    pop_one();
    check("t6_empty", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
